// File: rtl/spi_master_cfg_if.sv
// Request/response handshake between the DDS register sequencer and the SPI engine.
// The sequencer owns the master modport; the SPI engine owns the slave modport.
interface spi_master_cfg_if #(
  parameter int DATA_W = 32,
  parameter int NB_W   = 6
);
  logic              start;
  logic [DATA_W-1:0] in;
  logic [NB_W-1:0]   nbits;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] out;

  modport master (output start, in, nbits, input busy, done, out);
  modport slave  (input start, in, nbits, output busy, done, out);
endinterface

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with per-transfer bit count, any CPOL/CPHA mode,
// programmable SCLK half-period and CS setup/hold spacing.
module spi_master_cfg #(
  parameter int DATA_W   = 32,
  parameter int NB_W     = 6,
  parameter int CLK_DIV  = 2,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_cfg_if.slave  bus,
  input  logic             MISO,
  output logic             SCLK,
  output logic             MOSI,
  output logic             CS
);

  localparam int EW     = $clog2(2 * DATA_W + 1);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int NBX    = NB_W + 1;
  localparam logic [NBX-1:0] DW_NB    = NBX'(DATA_W);
  localparam logic           IDLE_LVL = 1'(CPOL);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [PH_W-1:0]   ph_reg, ph_next;
  logic [EW-1:0]     edge_reg, edge_next;
  logic [EW-1:0]     n2_reg, n2_next;
  logic [DATA_W-1:0] tx_reg, tx_next;
  logic [DATA_W-1:0] rx_reg, rx_next;
  logic [DATA_W-1:0] out_reg, out_next;
  logic              sclk_reg, sclk_next;
  logic              mosi_reg, mosi_next;
  logic              cs_reg, cs_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              start_q_reg, start_q_next;

  logic [EW-1:0]     n_eff;
  logic [EW-1:0]     shamt;
  logic [DATA_W-1:0] tx_load;
  logic              do_edge;
  logic              leading;

  // Zero or oversize bit counts mean a full-width transfer.
  always_comb begin
    if (bus.nbits == '0 || {1'b0, bus.nbits} > DW_NB) begin
      n_eff = EW'(DATA_W);
    end else begin
      n_eff = EW'(bus.nbits);
    end
    shamt   = EW'(DATA_W) - n_eff;
    tx_load = bus.in << shamt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      div_reg     <= '0;
      ph_reg      <= '0;
      edge_reg    <= '0;
      n2_reg      <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      out_reg     <= '0;
      sclk_reg    <= IDLE_LVL;
      mosi_reg    <= 1'b0;
      cs_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      start_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      ph_reg      <= ph_next;
      edge_reg    <= edge_next;
      n2_reg      <= n2_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      out_reg     <= out_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      cs_reg      <= cs_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      start_q_reg <= start_q_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    ph_next      = ph_reg;
    edge_next    = edge_reg;
    n2_next      = n2_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    out_next     = out_reg;
    sclk_next    = sclk_reg;
    mosi_next    = mosi_reg;
    cs_next      = cs_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    start_q_next = bus.start;
    do_edge      = 1'b0;
    leading      = ~edge_reg[0];

    case (state_reg)
      IDLE: begin
        if (bus.start && !start_q_reg) begin
          state_next = SETUP;
          cs_next    = 1'b0;
          busy_next  = 1'b1;
          ph_next    = '0;
          edge_next  = '0;
          n2_next    = n_eff << 1;
          tx_next    = tx_load;
          rx_next    = '0;
          mosi_next  = tx_load[DATA_W-1];
        end
      end
      SETUP: begin
        // The first SCLK edge lands exactly CS_SETUP cycles after CS falls.
        if (ph_reg == PH_W'(CS_SETUP - 1)) begin
          state_next = SHIFT;
          div_next   = '0;
          do_edge    = 1'b1;
        end else begin
          ph_next = ph_reg + 1'b1;
        end
      end
      SHIFT: begin
        if (div_reg == DIV_W'(CLK_DIV - 1)) begin
          div_next = '0;
          if (edge_reg == n2_reg) begin
            state_next = HOLD;
            ph_next    = '0;
          end else begin
            do_edge = 1'b1;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      HOLD: begin
        if (ph_reg == PH_W'(CS_HOLD - 1)) begin
          state_next = IDLE;
          cs_next    = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          out_next   = rx_reg;
          mosi_next  = 1'b0;
        end else begin
          ph_next = ph_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Edge numbering starts at 1, so odd-numbered edges are leading edges.
    if (do_edge) begin
      edge_next = edge_reg + 1'b1;
      sclk_next = ~sclk_reg;
      if (leading == (CPHA == 0)) begin
        rx_next = {rx_reg[DATA_W-2:0], MISO};
      end else if (CPHA == 0) begin
        if (edge_reg + 1'b1 != n2_reg) begin
          tx_next   = tx_reg << 1;
          mosi_next = tx_reg[DATA_W-2];
        end
      end else begin
        mosi_next = tx_reg[DATA_W-1];
        tx_next   = tx_reg << 1;
      end
    end
  end

  assign SCLK     = sclk_reg;
  assign MOSI     = mosi_reg;
  assign CS       = cs_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.out  = out_reg;

endmodule
